me_search_ctrl: RTL and testbench



---
 rtl/me_search_ctrl.sv | 158 +++++++++++++++
 tb/tb_me_search_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/me_search_ctrl.sv
// Full-search scheduler for the 8x8 SAD datapath: issues every displacement in raster
// order, aligns the returning SADs with their displacement and keeps the earliest minimum.
module me_search_ctrl #(
  parameter int RANGE   = 4,
  parameter int MVW     = 4,
  parameter int SAD_LAT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           cand_ready,
  output logic           cand_valid,
  output logic [MVW-1:0] cand_dx,
  output logic [MVW-1:0] cand_dy,
  input  logic [13:0]    sad_in,
  output logic           busy,
  output logic           done,
  output logic [MVW-1:0] mv_x,
  output logic [MVW-1:0] mv_y,
  output logic [13:0]    min_sad,
  output logic [1:0]     dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [MVW-1:0] MIN_V = MVW'(-RANGE);
  localparam logic [MVW-1:0] MAX_V = MVW'(RANGE - 1);

  state_e         state_q;
  logic [MVW-1:0] cnt_x_q, cnt_y_q;
  logic           cand_valid_q;
  logic [MVW-1:0] cand_dx_q, cand_dy_q;
  logic           busy_q, done_q;
  logic [MVW-1:0] mv_x_q, mv_y_q;
  logic [13:0]    min_sad_q;
  logic           first_q;
  logic [MVW-1:0] best_x_q, best_y_q;
  logic [13:0]    best_sad_q;
  logic           dl_v_q [SAD_LAT];
  logic [MVW-1:0] dl_x_q [SAD_LAT];
  logic [MVW-1:0] dl_y_q [SAD_LAT];

  logic           issue_go, last_cand, samp_load, last_samp;
  logic [MVW-1:0] cur_x, cur_y, nxt_x, nxt_y;
  logic [MVW-1:0] best_x_d, best_y_d;
  logic [13:0]    best_sad_d;

  // Handshake: a candidate is taken on every edge where cand_ready=1 while issuing
  // (including the start edge); it appears on cand_valid/cand_dx/cand_dy the next cycle.
  always_comb begin
    cur_x      = (state_q == S_IDLE) ? MIN_V : cnt_x_q;
    cur_y      = (state_q == S_IDLE) ? MIN_V : cnt_y_q;
    issue_go   = cand_ready && ((state_q == S_ISSUE) || ((state_q == S_IDLE) && start));
    last_cand  = (cur_x == MAX_V) && (cur_y == MAX_V);
    nxt_x      = (cur_x == MAX_V) ? MIN_V : cur_x + MVW'(1);
    nxt_y      = (cur_x == MAX_V) ? cur_y + MVW'(1) : cur_y;
    samp_load  = dl_v_q[SAD_LAT-1] && (first_q || (sad_in < best_sad_q));
    best_x_d   = samp_load ? dl_x_q[SAD_LAT-1] : best_x_q;
    best_y_d   = samp_load ? dl_y_q[SAD_LAT-1] : best_y_q;
    best_sad_d = samp_load ? sad_in : best_sad_q;
    last_samp  = dl_v_q[SAD_LAT-1] && (dl_x_q[SAD_LAT-1] == MAX_V)
                 && (dl_y_q[SAD_LAT-1] == MAX_V);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_x_q      <= '0;
      cnt_y_q      <= '0;
      cand_valid_q <= 1'b0;
      cand_dx_q    <= '0;
      cand_dy_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mv_x_q       <= '0;
      mv_y_q       <= '0;
      min_sad_q    <= '0;
      first_q      <= 1'b0;
      best_x_q     <= '0;
      best_y_q     <= '0;
      best_sad_q   <= '0;
      for (int i = 0; i < SAD_LAT; i++) begin
        dl_v_q[i] <= 1'b0;
        dl_x_q[i] <= '0;
        dl_y_q[i] <= '0;
      end
    end else begin
      cand_valid_q <= 1'b0;
      done_q       <= 1'b0;
      // The sum tree never stalls, so the alignment line shifts every cycle.
      dl_v_q[0] <= cand_valid_q;
      dl_x_q[0] <= cand_dx_q;
      dl_y_q[0] <= cand_dy_q;
      for (int i = 1; i < SAD_LAT; i++) begin
        dl_v_q[i] <= dl_v_q[i-1];
        dl_x_q[i] <= dl_x_q[i-1];
        dl_y_q[i] <= dl_y_q[i-1];
      end
      if (dl_v_q[SAD_LAT-1]) begin
        first_q    <= 1'b0;
        best_x_q   <= best_x_d;
        best_y_q   <= best_y_d;
        best_sad_q <= best_sad_d;
      end
      if (issue_go) begin
        cand_valid_q <= 1'b1;
        cand_dx_q    <= cur_x;
        cand_dy_q    <= cur_y;
        cnt_x_q      <= nxt_x;
        cnt_y_q      <= nxt_y;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= (issue_go && last_cand) ? S_DRAIN : S_ISSUE;
            busy_q  <= 1'b1;
            first_q <= 1'b1;
            if (!cand_ready) begin
              cnt_x_q <= MIN_V;
              cnt_y_q <= MIN_V;
            end
          end
        end
        S_ISSUE: begin
          if (issue_go && last_cand) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (last_samp) begin
            state_q   <= S_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            mv_x_q    <= best_x_d;
            mv_y_q    <= best_y_d;
            min_sad_q <= best_sad_d;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cand_valid = cand_valid_q;
  assign cand_dx    = cand_dx_q;
  assign cand_dy    = cand_dy_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign mv_x       = mv_x_q;
  assign mv_y       = mv_y_q;
  assign min_sad    = min_sad_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_me_search_ctrl.sv
// Bench for me_search_ctrl: random SAD maps and stalls, a datapath model returning SADs
// SAD_LAT cycles after each candidate, and a scoreboard checked by an independent monitor.
module tb_me_search_ctrl;
  localparam int R   = 4;
  localparam int MVW = 4;
  localparam int LAT = 4;
  localparam int SD  = 2 * R;
  localparam int N   = SD * SD;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           cand_ready = 1'b0;
  logic           cand_valid;
  logic [MVW-1:0] cand_dx, cand_dy;
  logic [13:0]    sad_in = 14'd0;
  logic           busy, done;
  logic [MVW-1:0] mv_x, mv_y;
  logic [13:0]    min_sad;
  logic [1:0]     dbg_state;

  me_search_ctrl #(.RANGE(R), .MVW(MVW), .SAD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cand_ready(cand_ready),
    .cand_valid(cand_valid), .cand_dx(cand_dx), .cand_dy(cand_dy), .sad_in(sad_in),
    .busy(busy), .done(done), .mv_x(mv_x), .mv_y(mv_y), .min_sad(min_sad),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  logic [2*MVW-1:0]    exp_cand_q[$];
  logic [2*MVW+13:0]   exp_res_q[$];
  int                  exp_done_q[$];
  int sad_map [SD][SD];
  bit start_req = 1'b0, junk_req = 1'b0, rst_req = 1'b1;
  int rdy_pct = 0;
  bit model_active = 1'b0;
  int model_cnt = 0;
  int cand_seen = 0, done_seen = 0;
  logic           hv [8] = '{default: 1'b0};
  logic [MVW-1:0] hx [8] = '{default: '0};
  logic [MVW-1:0] hy [8] = '{default: '0};

  task automatic check(input bit ok, input string name, input int act, input int expv);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: raster scan, strict less-than, so the earliest minimum wins.
  task automatic push_search();
    int bx, by, bs;
    bs = 32'h7fffffff; bx = 0; by = 0;
    for (int dy = -R; dy < R; dy++)
      for (int dx = -R; dx < R; dx++) begin
        exp_cand_q.push_back({MVW'(dx), MVW'(dy)});
        if (sad_map[dy+R][dx+R] < bs) begin
          bs = sad_map[dy+R][dx+R]; bx = dx; by = dy;
        end
      end
    exp_res_q.push_back({MVW'(bx), MVW'(by), 14'(bs)});
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < SD; i++)
      for (int j = 0; j < SD; j++) sad_map[i][j] = v;
  endtask

  task automatic fill_rand(input int mdx, input int mdy, input int mval);
    for (int i = 0; i < SD; i++)
      for (int j = 0; j < SD; j++) sad_map[i][j] = int'($urandom_range(16320, mval + 1));
    sad_map[mdy+R][mdx+R] = mval;
  endtask

  // ---------------- driver: inputs and datapath model, on the falling edge ----------------
  always @(negedge clk) begin
    int slot, old, ox, oy;
    slot = cyc % 8;
    hv[slot] = cand_valid; hx[slot] = cand_dx; hy[slot] = cand_dy;
    if (cyc >= LAT && hv[(cyc - LAT) % 8] === 1'b1) begin
      old = (cyc - LAT) % 8;
      ox = int'($signed(hx[old])) + R;
      oy = int'($signed(hy[old])) + R;
      sad_in = 14'(sad_map[oy][ox]);
    end else begin
      sad_in = 14'($urandom_range(16320, 0));
    end
    rst_n = !rst_req;
    if (rst_req) begin
      start = 1'b0;
      cand_ready = 1'b0;
      exp_cand_q.delete();
      exp_res_q.delete();
      exp_done_q.delete();
      model_active = 1'b0;
    end else begin
      cand_ready = (rdy_pct == 0) ? 1'b1 : ($urandom_range(99, 0) >= rdy_pct);
      start = start_req | junk_req;
      if (start_req) begin
        push_search();
        model_active = 1'b1;
        model_cnt = 0;
      end
      start_req = 1'b0;
      junk_req = 1'b0;
      if (model_active && cand_ready) begin
        model_cnt++;
        if (model_cnt == N) begin
          exp_done_q.push_back(cyc + LAT + 2);
          model_active = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor: pops and compares whenever the DUT presents output ----------------
  always @(posedge clk) begin
    logic [2*MVW-1:0]  ec;
    logic [2*MVW+13:0] er;
    int ed;
    #1;
    if (cand_valid === 1'b1) begin
      cand_seen++;
      check(cand_ready === 1'b1, "issue_without_ready", int'(cand_ready), 1);
      check(exp_cand_q.size() > 0, "unexpected_cand", cand_seen, 0);
      if (exp_cand_q.size() > 0) begin
        ec = exp_cand_q.pop_front();
        check(cand_dx == ec[2*MVW-1:MVW], "cand_dx",
              int'($signed(cand_dx)), int'($signed(ec[2*MVW-1:MVW])));
        check(cand_dy == ec[MVW-1:0], "cand_dy",
              int'($signed(cand_dy)), int'($signed(ec[MVW-1:0])));
      end
    end
    if (done === 1'b1) begin
      done_seen++;
      check(exp_res_q.size() > 0, "unexpected_done", done_seen, 0);
      if (exp_res_q.size() > 0) begin
        er = exp_res_q.pop_front();
        check(mv_x == er[2*MVW+13:MVW+14], "mv_x",
              int'($signed(mv_x)), int'($signed(er[2*MVW+13:MVW+14])));
        check(mv_y == er[MVW+13:14], "mv_y",
              int'($signed(mv_y)), int'($signed(er[MVW+13:14])));
        check(min_sad == er[13:0], "min_sad", int'(min_sad), int'(er[13:0]));
        check(busy === 1'b0, "busy_in_done", int'(busy), 0);
        ed = (exp_done_q.size() > 0) ? exp_done_q.pop_front() : -1;
        check(cyc == ed, "done_cycle", cyc, ed);
      end
    end
  end

  // ---------------- sequence ----------------
  task automatic launch();
    @(posedge clk); #2;
    start_req = 1'b1;
    @(posedge clk); #1;
    check(busy === 1'b1, "busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_done(input int limit);
    int base, n;
    base = done_seen; n = 0;
    while (done_seen == base && n < limit) begin
      @(posedge clk); #2;
      n++;
    end
    check(done_seen != base, "done_timeout", n, limit);
  endtask

  task automatic finish_report();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  initial begin
    int base, n;
    rst_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check(cand_valid === 1'b0, "rst_cand_valid", int'(cand_valid), 0);
    check(busy === 1'b0, "rst_busy", int'(busy), 0);
    check(done === 1'b0, "rst_done", int'(done), 0);
    check(mv_x === '0, "rst_mv_x", int'(mv_x), 0);
    check(mv_y === '0, "rst_mv_y", int'(mv_y), 0);
    check(min_sad === '0, "rst_min_sad", int'(min_sad), 0);
    rst_req = 1'b0;
    repeat (2) @(posedge clk);

    // Constant map: first sample wins, no stalls.
    fill_const(100);
    launch();
    wait_done(200);

    // Tie at 37: earlier raster position (2,-1) must win over (3,1).
    fill_const(16320);
    sad_map[-1+R][2+R] = 37;
    sad_map[1+R][3+R] = 37;
    launch();
    wait_done(200);

    // Random stalls with a unique minimum.
    rdy_pct = 50;
    fill_rand(-1, 3, 5);
    launch();
    wait_done(1000);
    rdy_pct = 0;

    // All maximum: the first sample must still load.
    fill_const(16320);
    launch();
    wait_done(200);

    // Reset at the 20th issue, then a fresh search.
    fill_rand(1, -2, 9);
    launch();
    base = cand_seen; n = 0;
    while (cand_seen - base < 20 && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    check(cand_seen - base >= 20, "wait_20th_issue", cand_seen - base, 20);
    rst_req = 1'b1;
    @(posedge clk); #1;
    rst_req = 1'b0;
    check(busy === 1'b0, "abort_busy", int'(busy), 0);
    check(min_sad === '0, "abort_min_sad", int'(min_sad), 0);
    base = done_seen;
    repeat (100) @(posedge clk);
    #2;
    check(done_seen == base, "abort_no_done", done_seen - base, 0);
    fill_rand(-4, 3, 0);
    launch();
    wait_done(200);

    // Starts during ISSUE and DRAIN are ignored; a start right after done is taken.
    fill_rand(3, -4, 17);
    launch();
    base = done_seen;
    repeat (10) @(posedge clk);
    #2;
    junk_req = 1'b1;
    n = 0;
    while (exp_cand_q.size() > 0 && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    junk_req = 1'b1;
    wait_done(200);
    fill_rand(0, 0, 1);
    launch();
    wait_done(200);
    check(done_seen - base == 2, "done_count", done_seen - base, 2);

    repeat (10) @(posedge clk);
    #2;
    check(exp_cand_q.size() == 0, "leftover_cands", exp_cand_q.size(), 0);
    check(exp_res_q.size() == 0, "leftover_results", exp_res_q.size(), 0);
    finish_report();
  end

  initial begin
    #(50000 * 10);
    bad++;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    finish_report();
  end

endmodule
